icache_nway: RTL and testbench

- Parametrised successor to the current 2-way instruction cache: N-way set-associative, configurable set count, line length and fetch width.
- Sits between the fetch stage and the AXI read-only instruction port.
- Adds four things the 2-way cache does not have: a request-ready handshake for back-to-back hits, invalid-way-first round-robin replacement, whole-cache invalidate, and flush-safe AXI draining.
- Tag, valid and data arrays are internal register arrays; no vendor RAM IP.

---
 rtl/icache_nway.sv | 244 ++++++++++++++++++++++++
 tb/tb_icache_nway.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction cache between the fetch stage and an AXI read-only port.
// Build macro ICACHE_PERF_EN adds wrapping hit/miss counters on perf_hit / perf_miss.
module icache_nway #(
  parameter int WAYS        = 2,
  parameter int SETS        = 256,
  parameter int LINE_WORDS  = 4,
  parameter int FETCH_WORDS = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      rvalid,
  input  logic [31:0]               raddr,
  input  logic                      uncache,
  input  logic                      is_flush,
  input  logic                      inv_all,
  output logic                      req_ready,
  output logic                      rready,
  output logic [32*FETCH_WORDS-1:0] rdata,
  output logic [FETCH_WORDS-1:0]    fetch_mask,
  output logic                      inv_done,
  output logic                      i_arvalid,
  output logic [31:0]               i_araddr,
  output logic [7:0]                i_arlen,
  input  logic                      i_arready,
  input  logic                      i_rvalid,
  input  logic [31:0]               i_rdata,
  input  logic                      i_rlast,
  output logic                      i_rready
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]               perf_hit,
  output logic [31:0]               perf_miss
`endif
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 30 - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_AR, S_REFILL, S_RESP, S_INVAL} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q;
  logic               unc_q;
  logic               kill_q, kill_d;
  logic [OFF_W:0]     cnt_q, cnt_d;
  logic [LINE_W-1:0]  buf_q, buf_d, fill_line, line_sel;
  logic [OFF_W:0]     pos;

  logic               valid_q [WAYS][SETS];
  logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
  logic [LINE_W-1:0]  data_q  [WAYS][SETS];
  logic [WAY_W-1:0]   ptr_q   [SETS];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [OFF_W-1:0]   off;
  logic               hit;
  logic [WAY_W-1:0]   hit_way, victim;
  logic               accept, hit_upd, fill_we, inv_en;
  logic               unused_addr_bits;

  assign idx = addr_q[OFF_W+2 +: IDX_W];
  assign tag = addr_q[31 -: TAG_W];
  assign off = addr_q[2 +: OFF_W];
  assign unused_addr_bits = ^addr_q[1:0];

  function automatic logic [WAY_W-1:0] next_way(input logic [WAY_W-1:0] w);
    return (int'(w) == WAYS - 1) ? '0 : w + 1'b1;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise the round-robin pointer picks the victim.
  always_comb begin
    victim = ptr_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) victim = WAY_W'(w);
    end
  end

  always_comb begin
    fill_line = buf_q;
    if (i_rvalid && cnt_q < (OFF_W+1)'(LINE_WORDS))
      fill_line[32*int'(cnt_q[OFF_W-1:0]) +: 32] = i_rdata;
  end

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    req_ready = 1'b0;
    rready    = 1'b0;
    inv_done  = 1'b0;
    i_arvalid = 1'b0;
    i_rready  = 1'b0;
    accept    = 1'b0;
    hit_upd   = 1'b0;
    fill_we   = 1'b0;
    inv_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (inv_all) begin
          state_d = S_INVAL;
        end else if (rvalid && !is_flush) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (is_flush) begin
          state_d = S_IDLE;
        end else if (hit && !unc_q) begin
          rready    = 1'b1;
          req_ready = 1'b1;
          hit_upd   = 1'b1;
          accept    = rvalid;
          state_d   = rvalid ? S_LOOKUP : S_IDLE;
        end else begin
          kill_d  = 1'b0;
          buf_d   = '0;
          state_d = S_AR;
        end
      end
      S_AR: begin
        i_arvalid = 1'b1;
        if (is_flush) kill_d = 1'b1;
        if (i_arready) begin
          cnt_d   = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        i_rready = 1'b1;
        if (is_flush) kill_d = 1'b1;
        if (i_rvalid) begin
          buf_d = fill_line;
          if (cnt_q < (OFF_W+1)'(LINE_WORDS)) cnt_d = cnt_q + 1'b1;
          if (i_rlast) begin
            fill_we = !unc_q;
            state_d = (kill_q || is_flush) ? S_IDLE : S_RESP;
          end
        end
      end
      S_RESP: begin
        rready  = !is_flush;
        state_d = S_IDLE;
      end
      S_INVAL: begin
        inv_en   = 1'b1;
        inv_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign i_araddr = (state_q != S_AR) ? '0 :
                    unc_q ? {addr_q[31:2], 2'b00} : {addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign i_arlen  = (state_q != S_AR) ? '0 :
                    unc_q ? 8'(FETCH_WORDS - 1) : 8'(LINE_WORDS - 1);

  // Response words come from the hit way in LOOKUP, otherwise from the refill buffer.
  always_comb begin
    line_sel   = (state_q == S_LOOKUP) ? data_q[hit_way][idx] : buf_q;
    rdata      = '0;
    fetch_mask = '0;
    pos        = '0;
    for (int i = 0; i < FETCH_WORDS; i++) begin
      pos = {1'b0, off} + (OFF_W+1)'(i);
      if (rready && unc_q) begin
        rdata[32*i +: 32] = buf_q[32*i +: 32];
        fetch_mask[i]     = 1'b1;
      end else if (rready && pos < (OFF_W+1)'(LINE_WORDS)) begin
        rdata[32*i +: 32] = line_sel[32*int'(pos[OFF_W-1:0]) +: 32];
        fetch_mask[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) valid_q[w][s] <= 1'b0;
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
      if (inv_en) begin
        for (int w = 0; w < WAYS; w++)
          for (int s = 0; s < SETS; s++) valid_q[w][s] <= 1'b0;
      end else if (fill_we) begin
        valid_q[victim][idx] <= 1'b1;
      end
      if (fill_we)      ptr_q[idx] <= next_way(victim);
      else if (hit_upd) ptr_q[idx] <= next_way(hit_way);
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (accept) begin
      addr_q <= raddr;
      unc_q  <= uncache;
    end
    if (fill_we) begin
      tag_q[victim][idx]  <= tag;
      data_q[victim][idx] <= fill_line;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      if (hit_upd) perf_hit_q <= perf_hit_q + 1'b1;
      if (state_q == S_LOOKUP && state_d == S_AR && !unc_q) perf_miss_q <= perf_miss_q + 1'b1;
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`endif
endmodule

// File: tb/tb_icache_nway.sv
// Randomised self-checking bench for icache_nway against a set/way/pointer reference model and an AXI memory slave.
`timescale 1ns/1ps
module tb_icache_nway;
  localparam int WAYS = 2;
  localparam int SETS = 256;
  localparam int LW   = 4;
  localparam int FW   = 2;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        rvalid = 1'b0, uncache = 1'b0, is_flush = 1'b0, inv_all = 1'b0;
  logic [31:0] raddr = '0;
  logic        req_ready, rready, inv_done, i_arvalid, i_rready;
  logic [63:0] rdata;
  logic [1:0]  fetch_mask;
  logic [31:0] i_araddr;
  logic [7:0]  i_arlen;
  logic        i_arready = 1'b0, i_rvalid = 1'b0, i_rlast = 1'b0;
  logic [31:0] i_rdata = '0;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit, perf_miss;
`endif

  int total = 0, bad = 0;

  icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .FETCH_WORDS(FW)) dut (
    .clk(clk), .rstn(rstn), .rvalid(rvalid), .raddr(raddr), .uncache(uncache),
    .is_flush(is_flush), .inv_all(inv_all), .req_ready(req_ready), .rready(rready),
    .rdata(rdata), .fetch_mask(fetch_mask), .inv_done(inv_done),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rready(i_rready)
`ifdef ICACHE_PERF_EN
    , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          mv   [SETS][WAYS];
  logic [19:0] mt   [SETS][WAYS];
  int          mptr [SETS];
  int          m_hits = 0, m_misses = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h1000) >> 2);
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
  endfunction

  function automatic bit model_access(input logic [31:0] a, input bit unc);
    int s = int'(a[11:4]);
    logic [19:0] t = a[31:12];
    int v;
    if (unc) return 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mt[s][w] == t) begin
        mptr[s] = (w + 1) % WAYS;
        m_hits++;
        return 1'b1;
      end
    v = mptr[s];
    for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) v = w;
    mv[s][v] = 1'b1;
    mt[s][v] = t;
    mptr[s]  = (v + 1) % WAYS;
    m_misses++;
    return 1'b0;
  endfunction

  function automatic void exp_resp(input logic [31:0] a, input bit unc,
                                   output logic [63:0] d, output logic [1:0] m);
    int off = int'(a[3:2]);
    d = '0;
    m = '0;
    for (int i = 0; i < FW; i++) begin
      if (unc) begin
        d[32*i +: 32] = mem({a[31:2], 2'b00} + 32'(4*i));
        m[i] = 1'b1;
      end else if (off + i < LW) begin
        d[32*i +: 32] = mem({a[31:4], 4'b0000} + 32'(4*(off+i)));
        m[i] = 1'b1;
      end
    end
  endfunction

  // ---------------- AXI read slave ----------------
  int          ar_cnt = 0, beats_total = 0, bursts_done = 0, ar_unstable = 0, rr_stall = 0;
  int          cur_beat = -1;
  logic [31:0] last_araddr = '0;
  logic [7:0]  last_arlen = '0;
  time         rlast_time = 0, resp_time = 0;

  initial begin : slave
    logic [31:0] a0;
    logic [7:0]  l0;
    bit          ok;
    forever begin
      @(negedge clk);
      if (i_arvalid === 1'b1) begin
        a0 = i_araddr;
        l0 = i_arlen;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (i_araddr !== a0 || i_arlen !== l0 || i_arvalid !== 1'b1) ar_unstable++;
        i_arready = 1'b1;
        @(posedge clk);
        #1 i_arready = 1'b0;
        ar_cnt++;
        last_araddr = a0;
        last_arlen  = l0;
        for (int b = 0; b <= int'(l0); b++) begin
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          i_rvalid = 1'b1;
          i_rdata  = mem(a0 + 32'(4*b));
          i_rlast  = (b == int'(l0));
          cur_beat = b;
          ok = 1'b0;
          for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = (i_rready === 1'b1);
            if (!ok) rr_stall++;
            @(posedge clk);
            if (ok && i_rlast) rlast_time = $time;
            #1;
          end
          i_rvalid = 1'b0;
          i_rlast  = 1'b0;
          cur_beat = -1;
          beats_total++;
        end
        bursts_done++;
      end
    end
  end

  // ---------------- fetch driver ----------------
  task automatic fetch(input logic [31:0] a, input bit unc, input int flush_beat,
                       output bit got, output logic [63:0] d, output logic [1:0] m, output int lat);
    int k = 0;
    got = 1'b0;
    lat = 0;
    d = '0;
    m = '0;
    @(negedge clk);
    while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    rvalid = 1'b1;
    raddr = a;
    uncache = unc;
    @(posedge clk);
    #1 rvalid = 1'b0;
    uncache = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (flush_beat >= 0 && i_rvalid === 1'b1 && cur_beat == flush_beat) is_flush = 1'b1;
      if (rready === 1'b1 && !got) begin
        got = 1'b1;
        lat = c;
        d = rdata;
        m = fetch_mask;
        resp_time = $time;
      end
      if (got && flush_beat < 0) break;
      @(posedge clk);
      #1 is_flush = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    model_clear();
    for (int s = 0; s < SETS; s++) mptr[s] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({rready, inv_done, i_arvalid, i_rready, i_araddr, i_arlen} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rready=%b inv_done=%b arvalid=%b rready_axi=%b araddr=%h arlen=%h want all 0",
               rready, inv_done, i_arvalid, i_rready, i_araddr, i_arlen);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_cold_miss();
    bit got; logic [63:0] d; logic [1:0] m; int lat; int ar0 = ar_cnt;
    fetch(32'h0000_1008, 1'b0, -1, got, d, m, lat);
    void'(model_access(32'h0000_1008, 1'b0));
    total++; if (got !== 1'b1) begin bad++; $display("FAIL cold_rready: got %b want 1", got); end
    total++; if (ar_cnt - ar0 != 1) begin bad++; $display("FAIL cold_ar_count: got %0d want 1", ar_cnt - ar0); end
    total++; if (last_araddr !== 32'h0000_1000) begin bad++; $display("FAIL cold_araddr: got %h want 00001000", last_araddr); end
    total++; if (last_arlen !== 8'd3) begin bad++; $display("FAIL cold_arlen: got %0d want 3", last_arlen); end
    total++; if (d !== 64'h0000_00A3_0000_00A2) begin bad++; $display("FAIL cold_rdata: got %h want 000000a3000000a2", d); end
    total++; if (m !== 2'b11) begin bad++; $display("FAIL cold_mask: got %b want 11", m); end
    total++; if (resp_time - rlast_time != 5) begin bad++; $display("FAIL cold_latency: rready %0t after rlast edge, want 5", resp_time - rlast_time); end
  endtask

  task automatic test_back_to_back();
    int ar0 = ar_cnt;
    bit h1, h2;
    @(negedge clk);
    rvalid = 1'b1;
    raddr = 32'h0000_1008;
    uncache = 1'b0;
    @(posedge clk);
    #1 raddr = 32'h0000_100C;
    h1 = model_access(32'h0000_1008, 1'b0);
    @(negedge clk);
    total++; if (rready !== 1'b1 || req_ready !== 1'b1) begin bad++; $display("FAIL b2b_first: got rready=%b req_ready=%b want 1 1", rready, req_ready); end
    total++; if (rdata !== 64'h0000_00A3_0000_00A2 || fetch_mask !== 2'b11) begin bad++; $display("FAIL b2b_first_data: got %h/%b want 000000a3000000a2/11", rdata, fetch_mask); end
    @(posedge clk);
    #1 rvalid = 1'b0;
    h2 = model_access(32'h0000_100C, 1'b0);
    @(negedge clk);
    total++; if (rready !== 1'b1) begin bad++; $display("FAIL b2b_second: got rready=%b want 1", rready); end
    total++; if (rdata !== 64'h0000_0000_0000_00A3 || fetch_mask !== 2'b01) begin bad++; $display("FAIL b2b_second_data: got %h/%b want 00000000000000a3/01", rdata, fetch_mask); end
    total++; if (ar_cnt != ar0 || !(h1 && h2)) begin bad++; $display("FAIL b2b_no_ar: got %0d ARs (model hits %b%b) want 0", ar_cnt - ar0, h1, h2); end
  endtask

  task automatic test_evict();
    bit got; logic [63:0] d, ed; logic [1:0] m, em; int lat; int ar0; bit eh;
    logic [31:0] seq [3] = '{32'h0000_2000, 32'h0000_3000, 32'h0000_1000};
    for (int i = 0; i < 3; i++) begin
      ar0 = ar_cnt;
      fetch(seq[i], 1'b0, -1, got, d, m, lat);
      eh = model_access(seq[i], 1'b0);
      exp_resp(seq[i], 1'b0, ed, em);
      total++; if (got !== 1'b1 || (ar_cnt - ar0 == 0) !== eh) begin bad++; $display("FAIL evict_hit[%0d]: got rready=%b ars=%0d want model hit=%b", i, got, ar_cnt - ar0, eh); end
      total++; if (d !== ed || m !== em) begin bad++; $display("FAIL evict_data[%0d]: got %h/%b want %h/%b", i, d, m, ed, em); end
      if (i == 2) begin
        total++; if (ar_cnt - ar0 != 1) begin bad++; $display("FAIL evict_1000_misses: got %0d ARs want 1", ar_cnt - ar0); end
      end
    end
  endtask

  task automatic test_uncached();
    bit got; logic [63:0] d; logic [1:0] m; int lat; int ar0;
    logic [63:0] want = {mem(32'h8000_0008), mem(32'h8000_0004)};
    for (int r = 0; r < 2; r++) begin
      ar0 = ar_cnt;
      fetch(32'h8000_0004, 1'b1, -1, got, d, m, lat);
      void'(model_access(32'h8000_0004, 1'b1));
      total++; if (ar_cnt - ar0 != 1 || got !== 1'b1) begin bad++; $display("FAIL unc_miss[%0d]: got ARs=%0d rready=%b want 1 1", r, ar_cnt - ar0, got); end
      total++; if (last_araddr !== 32'h8000_0004 || last_arlen !== 8'd1) begin bad++; $display("FAIL unc_ar[%0d]: got %h len %0d want 80000004 len 1", r, last_araddr, last_arlen); end
      total++; if (d !== want || m !== 2'b11) begin bad++; $display("FAIL unc_data[%0d]: got %h/%b want %h/11", r, d, m, want); end
    end
  endtask

  task automatic test_flush();
    bit got; logic [63:0] d, ed; logic [1:0] m, em; int lat;
    int ar0 = ar_cnt, b0 = beats_total, bd0 = bursts_done, st0 = rr_stall;
    fetch(32'h0000_5004, 1'b0, 1, got, d, m, lat);
    void'(model_access(32'h0000_5004, 1'b0));
    total++; if (got !== 1'b0) begin bad++; $display("FAIL flush_no_rready: got %b want 0", got); end
    total++; if (bursts_done - bd0 != 1 || beats_total - b0 != LW || ar_cnt - ar0 != 1) begin bad++; $display("FAIL flush_drain: got bursts=%0d beats=%0d ars=%0d want 1 %0d 1", bursts_done - bd0, beats_total - b0, ar_cnt - ar0, LW); end
    total++; if (rr_stall != st0) begin bad++; $display("FAIL flush_rready_held: got %0d stalled beats want 0", rr_stall - st0); end
    ar0 = ar_cnt;
    fetch(32'h0000_5004, 1'b0, -1, got, d, m, lat);
    exp_resp(32'h0000_5004, 1'b0, ed, em);
    total++; if (ar_cnt != ar0 || lat != 1 || !model_access(32'h0000_5004, 1'b0)) begin bad++; $display("FAIL flush_refetch_hit: got ARs=%0d lat=%0d want 0 1", ar_cnt - ar0, lat); end
    total++; if (d !== ed || m !== em) begin bad++; $display("FAIL flush_refetch_data: got %h/%b want %h/%b", d, m, ed, em); end
  endtask

  task automatic test_inval();
    bit got; logic [63:0] d, ed; logic [1:0] m, em; int lat; int ar0; bit eh;
    for (int pass = 0; pass < 2; pass++)
      for (int i = 0; i < 4; i++) begin
        ar0 = ar_cnt;
        fetch(32'h0000_6000 + 32'(16*i), 1'b0, -1, got, d, m, lat);
        eh = model_access(32'h0000_6000 + 32'(16*i), 1'b0);
        total++; if ((ar_cnt == ar0) !== eh || (pass == 1 && lat != 1)) begin bad++; $display("FAIL warm[%0d][%0d]: got ARs=%0d lat=%0d want hit=%b", pass, i, ar_cnt - ar0, lat, eh); end
      end
    @(negedge clk);
    inv_all = 1'b1;
    @(posedge clk);
    #1 inv_all = 1'b0;
    model_clear();
    @(negedge clk);
    total++; if (inv_done !== 1'b1) begin bad++; $display("FAIL inv_done_pulse: got %b want 1", inv_done); end
    @(negedge clk);
    total++; if (inv_done !== 1'b0) begin bad++; $display("FAIL inv_done_single: got %b want 0", inv_done); end
    for (int i = 0; i < 4; i++) begin
      ar0 = ar_cnt;
      fetch(32'h0000_6000 + 32'(16*i), 1'b0, -1, got, d, m, lat);
      eh = model_access(32'h0000_6000 + 32'(16*i), 1'b0);
      exp_resp(32'h0000_6000 + 32'(16*i), 1'b0, ed, em);
      total++; if (ar_cnt - ar0 != 1 || eh || d !== ed) begin bad++; $display("FAIL inv_miss[%0d]: got ARs=%0d data %h want 1 %h", i, ar_cnt - ar0, d, ed); end
    end
`ifdef ICACHE_PERF_EN
    total++; if (perf_hit !== 32'(m_hits)) begin bad++; $display("FAIL perf_hit: got %0d want %0d", perf_hit, m_hits); end
    total++; if (perf_miss !== 32'(m_misses)) begin bad++; $display("FAIL perf_miss: got %0d want %0d", perf_miss, m_misses); end
`endif
  endtask

  task automatic test_random();
    bit got; logic [63:0] d, ed; logic [1:0] m, em; int lat; int ar0; bit eh, unc;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      a = (32'($urandom_range(7, 9)) << 12) | (32'($urandom_range(0, 1)) << 4) | (32'($urandom_range(0, 3)) << 2);
      unc = ($urandom_range(0, 9) == 0);
      ar0 = ar_cnt;
      fetch(a, unc, -1, got, d, m, lat);
      eh = model_access(a, unc);
      exp_resp(a, unc, ed, em);
      total++; if (got !== 1'b1 || (ar_cnt == ar0) !== eh || (eh && lat != 1)) begin bad++; $display("FAIL rand_hit[%0d] a=%h: got rready=%b ARs=%0d lat=%0d want hit=%b", n, a, got, ar_cnt - ar0, lat, eh); end
      total++; if (d !== ed || m !== em) begin bad++; $display("FAIL rand_data[%0d] a=%h: got %h/%b want %h/%b", n, a, d, m, ed, em); end
    end
    total++; if (ar_unstable != 0) begin bad++; $display("FAIL ar_stable: got %0d unstable AR holds want 0", ar_unstable); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_evict();
    test_uncached();
    test_flush();
    test_inval();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
